// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OP_WIDTH   = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  function automatic logic op_is_signed(md_op_e op);
    return op[0];
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage connection to the multiply/divide unit: request, MTHI/MTLO, HI/LO and status.
interface muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH
);

  logic                   start;
  mips_pkg::md_op_e       md_op;
  logic [DATA_WIDTH-1:0]  operand_a;
  logic [DATA_WIDTH-1:0]  operand_b;
  logic                   hi_wr;
  logic                   lo_wr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [DATA_WIDTH-1:0]  hi;
  logic [DATA_WIDTH-1:0]  lo;
  logic                   busy;
  logic                   done;

  modport master (
    output start, md_op, operand_a, operand_b, hi_wr, lo_wr, wr_data,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, md_op, operand_a, operand_b, hi_wr, lo_wr, wr_data,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/muldiv_fsm.sv
// Sequencer for the iterative multiply/divide: state, iteration counter, op latch, busy/done.
module muldiv_fsm #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  mips_pkg::md_op_e    md_op_i,
  output mips_pkg::md_state_e state_o,
  output mips_pkg::md_op_e    op_o,
  output logic                busy_o,
  output logic                done_o
);

  import mips_pkg::*;

  md_state_e        state_q;
  md_op_e           op_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             done_q;

  // IDLE -> RUN for DATA_WIDTH iterations -> FIX for one cycle -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= MD_MULTU;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q    <= md_op_i;
            count_q <= CNT_W'(DATA_WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (count_q == '0) begin
            state_q <= S_FIX;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign op_o    = op_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide datapath with architectural HI/LO; one result bit per cycle.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  import mips_pkg::*;

  localparam int unsigned PW = 2 * DATA_WIDTH;

  md_state_e state;
  md_op_e    op;
  logic      busy;
  logic      done;

  muldiv_fsm #(.DATA_WIDTH(DATA_WIDTH)) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .start_i (bus.start),
    .md_op_i (bus.md_op),
    .state_o (state),
    .op_o    (op),
    .busy_o  (busy),
    .done_o  (done)
  );

  logic [DATA_WIDTH-1:0] hi_q, lo_q;
  logic [DATA_WIDTH-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [DATA_WIDTH-1:0] quo_q;    // multiplier / product low, or dividend / quotient
  logic [DATA_WIDTH:0]   rem_q;    // product high, or partial remainder
  logic                  neg_prod_q;
  logic                  neg_rem_q;

  logic                  start_acc;
  logic [DATA_WIDTH-1:0] a_abs, b_abs;
  logic [DATA_WIDTH:0]   add_sum, shifted, trial;
  logic                  can_sub;
  logic [DATA_WIDTH:0]   rem_d;
  logic [DATA_WIDTH-1:0] quo_d;
  logic [PW-1:0]         prod, prod_fix;
  logic [DATA_WIDTH-1:0] quo_fix, rem_fix;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] hi_res, lo_res;

  // Operand magnitudes for the load cycle
  always_comb begin
    start_acc = (state == S_IDLE) && bus.start;
    a_abs     = bus.operand_a;
    b_abs     = bus.operand_b;
    if (op_is_signed(bus.md_op)) begin
      if (bus.operand_a[DATA_WIDTH-1]) a_abs = ~bus.operand_a + DATA_WIDTH'(1);
      if (bus.operand_b[DATA_WIDTH-1]) b_abs = ~bus.operand_b + DATA_WIDTH'(1);
    end
  end

  // One shift-add or one restoring-subtract step per cycle
  always_comb begin
    add_sum = rem_q + (quo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {rem_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    can_sub = (shifted >= {1'b0, opnd_q});
    if (op_is_div(op)) begin
      rem_d = can_sub ? trial : shifted;
      quo_d = {quo_q[DATA_WIDTH-2:0], can_sub};
    end else begin
      rem_d = {1'b0, add_sum[DATA_WIDTH:1]};
      quo_d = {add_sum[0], quo_q[DATA_WIDTH-1:1]};
    end
  end

  // Sign fix-up; a zero divisor keeps the all-ones quotient unnegated
  always_comb begin
    div_zero = (opnd_q == '0);
    prod     = {rem_q[DATA_WIDTH-1:0], quo_q};
    prod_fix = neg_prod_q ? (~prod + PW'(1)) : prod;
    quo_fix  = (neg_prod_q && !div_zero) ? (~quo_q + DATA_WIDTH'(1)) : quo_q;
    rem_fix  = neg_rem_q ? (~rem_q[DATA_WIDTH-1:0] + DATA_WIDTH'(1)) : rem_q[DATA_WIDTH-1:0];
    if (op_is_div(op)) begin
      hi_res = rem_fix;
      lo_res = quo_fix;
    end else begin
      hi_res = prod_fix[PW-1:DATA_WIDTH];
      lo_res = prod_fix[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_acc) begin
            opnd_q     <= op_is_div(bus.md_op) ? b_abs : a_abs;
            quo_q      <= op_is_div(bus.md_op) ? a_abs : b_abs;
            rem_q      <= '0;
            neg_prod_q <= op_is_signed(bus.md_op) &&
                          (bus.operand_a[DATA_WIDTH-1] ^ bus.operand_b[DATA_WIDTH-1]);
            neg_rem_q  <= op_is_signed(bus.md_op) && bus.operand_a[DATA_WIDTH-1];
          end else begin
            if (bus.hi_wr) hi_q <= bus.wr_data;
            if (bus.lo_wr) lo_q <= bus.wr_data;
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
        end
        S_FIX: begin
          hi_q <= hi_res;
          lo_q <= lo_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule
